sync_ram: RTL

Parametrised synchronous single-port RAM; next generation of the 16x8 RAM in the memory directory. It adds a clock, a one-cycle registered read with a valid strobe, and a selectable read-during-write mode. A reset-triggered clear sequencer zeroes every word before the first access is accepted. It serves as CPU data/program memory where a deterministic power-up image is required.

---
 rtl/sync_ram.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sync_ram.sv
// sync_ram -- parametrised synchronous single-port RAM with a registered read
// port, a read-valid strobe, a selectable read-during-write behaviour and a
// reset-triggered clear sequencer that zeroes every word before the first
// access is accepted.
//
// Parameters:
//   DATA_WIDTH      word width in bits
//   ADDR_WIDTH      address width; DEPTH = 2**ADDR_WIDTH words
//   READ_MODE       0 = read-first (old data on same-address read+write),
//                   1 = write-first (new data)
//   CLEAR_ON_RESET  1 = zero the array after every reset, 0 = leave it as is
//
// Ports:
//   clk         single rising-edge clock
//   rst_n       asynchronous active-low reset
//   address     word address for both read and write
//   write_en    write data_in to address at the rising edge
//   read_en     read address at the rising edge
//   data_in     write data
//   data_out    registered read data; holds the last value read
//   read_valid  high for one cycle after each accepted read
//   busy        clear sequence running; all port accesses are ignored
module sync_ram #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int READ_MODE      = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_valid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam bit WRITE_FIRST = (READ_MODE != 0);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   ptr_reg, ptr_next;

  // Single write port into the array, shared by the sequencer and the user.
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_accept;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Sequencer state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RESET_STATE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and write-port steering
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    mem_we     = 1'b0;
    mem_waddr  = address;
    mem_wdata  = data_in;
    rd_accept  = 1'b0;

    case (state_reg)
      S_CLEAR: begin
        // The port is ignored here; the sequencer owns the write port.
        mem_we    = 1'b1;
        mem_waddr = ptr_reg;
        mem_wdata = '0;
        ptr_next  = ptr_reg + ADDR_WIDTH'(1);
        if (ptr_reg == LAST_ADDR) begin
          state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        mem_we    = write_en;
        rd_accept = read_en;
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  assign busy = (state_reg == S_CLEAR);

  // ---------------------------------------------------------------------------
  // Array: no reset on the contents so it maps onto block RAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read. Read-first falls out of the non-blocking array update;
  // write-first forwards data_in when a write lands on the same edge (the
  // address is shared, so it is always the same word).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= rd_accept;
      if (rd_accept) begin
        if (WRITE_FIRST && write_en) begin
          data_out <= data_in;
        end else begin
          data_out <= mem[address];
        end
      end
    end
  end

endmodule
